// File: rtl/msg_schedule_pkg.sv
// Shared types, constants and sigma functions for the message schedule.
package msg_schedule_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GEN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int NUM_ROUNDS = 64;
    localparam int WINDOW     = 16;

    // sigma0(x) = ror7 ^ ror18 ^ shr3
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ror17 ^ ror19 ^ shr10
    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/msg_schedule_window.sv
// msg_window: 16-word sliding window of past schedule words plus the
// next-word adder. Entry WINDOW-1 is the newest word (W_t-1), entry 0 the
// oldest (W_t-16).
module msg_window
    import msg_schedule_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        shift_en,
    input  logic [31:0] shift_data,
    output logic [31:0] next_word
);

    logic [31:0] win_reg [WINDOW];

    generate
        for (genvar gi = 0; gi < WINDOW; gi++) begin : g_win
            // Each entry takes its newer neighbour on a shift; the top entry takes the new word
            always_ff @(posedge clk) begin
                if (reset) begin
                    win_reg[gi] <= '0;
                end else if (shift_en) begin
                    if (gi == WINDOW - 1) begin
                        win_reg[gi] <= shift_data;
                    end else begin
                        win_reg[gi] <= win_reg[gi + 1];
                    end
                end
            end
        end
    endgenerate

    // W_t = sigma1(W_t-2) + W_t-7 + sigma0(W_t-15) + W_t-16, wrapping mod 2^32
    assign next_word = sigma1(win_reg[WINDOW - 2]) + win_reg[WINDOW - 7]
                     + sigma0(win_reg[WINDOW - 15]) + win_reg[0];

endmodule

// File: rtl/msg_schedule.sv
// msg_schedule: loads 16 message words from memory, then expands them into
// the 64-word schedule W_0..W_63, one word per non-held cycle.
// Optional macro MSG_SCHEDULE_BSWAP_EN byte-reverses incoming message words
// (little-endian memories); default treats msg_data as big-endian.
module msg_schedule
    import msg_schedule_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    input  logic [31:0] msg_data,
    output logic        msg_enable,
    output logic [3:0]  msg_addr,
    output logic [31:0] W_out,
    output logic        W_valid,
    output logic [5:0]  W_idx,
    output logic        done
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0] LOAD_PENULT = 6'(WINDOW - 2);

    state_t      state_reg, state_next;
    logic [4:0]  rd_cnt_reg;
    logic        msg_enable_reg;
    logic [3:0]  msg_addr_reg;
    logic        data_vld_reg;
    logic [31:0] w_out_reg;
    logic        w_valid_reg;
    logic [5:0]  w_idx_reg;

    logic        load_cap;
    logic        gen_run;
    logic        gen_step;
    logic        shift_en;
    logic [31:0] word_in;
    logic [31:0] next_word;
    logic [31:0] shift_data;

`ifdef MSG_SCHEDULE_BSWAP_EN
    assign word_in = {msg_data[7:0], msg_data[15:8], msg_data[23:16], msg_data[31:24]};
`else
    assign word_in = msg_data;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: LOAD ends as word 15 is captured, GEN ends after W_63 is shown
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_LOAD;
            ST_LOAD: if (load_cap && w_valid_reg && w_idx_reg == LOAD_PENULT) state_next = ST_GEN;
            ST_GEN:  if (gen_run && w_idx_reg == LAST_IDX) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output/control decode from the current state
    always_comb begin
        done     = 1'b0;
        load_cap = 1'b0;
        gen_run  = 1'b0;
        gen_step = 1'b0;
        case (state_reg)
            ST_LOAD: load_cap = data_vld_reg;
            ST_GEN: begin
                gen_run  = !hold;
                gen_step = !hold && (w_idx_reg != LAST_IDX);
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Message read sequencer: 16 reads of addresses 0..15, one per LOAD cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_reg     <= '0;
            msg_enable_reg <= 1'b0;
            msg_addr_reg   <= '0;
            data_vld_reg   <= 1'b0;
        end else begin
            data_vld_reg <= msg_enable_reg;
            if (state_reg == ST_LOAD && !rd_cnt_reg[4]) begin
                msg_enable_reg <= 1'b1;
                msg_addr_reg   <= rd_cnt_reg[3:0];
                rd_cnt_reg     <= rd_cnt_reg + 5'd1;
            end else begin
                msg_enable_reg <= 1'b0;
                msg_addr_reg   <= '0;
                if (state_reg != ST_LOAD) rd_cnt_reg <= '0;
            end
        end
    end

    // Output word register: capture loaded words, step generated words, freeze on hold
    always_ff @(posedge clk) begin
        if (reset) begin
            w_out_reg   <= '0;
            w_valid_reg <= 1'b0;
            w_idx_reg   <= '0;
        end else if (load_cap) begin
            w_out_reg   <= word_in;
            w_valid_reg <= 1'b1;
            w_idx_reg   <= w_valid_reg ? w_idx_reg + 6'd1 : 6'd0;
        end else if (gen_step) begin
            w_out_reg   <= next_word;
            w_idx_reg   <= w_idx_reg + 6'd1;
        end else if (gen_run || state_reg == ST_IDLE || state_reg == ST_DONE) begin
            w_out_reg   <= '0;
            w_valid_reg <= 1'b0;
            w_idx_reg   <= '0;
        end
    end

    assign shift_en   = load_cap || gen_step;
    assign shift_data = load_cap ? word_in : next_word;

    msg_window u_window (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (shift_en),
        .shift_data (shift_data),
        .next_word  (next_word)
    );

    assign msg_enable = msg_enable_reg;
    assign msg_addr   = msg_addr_reg;
    assign W_out      = w_out_reg;
    assign W_valid    = w_valid_reg;
    assign W_idx      = w_idx_reg;

endmodule
